// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared state encoding and bus widths for the I2C target.
// Revision : 1.0
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_BYTE  = 3'd3,
        WR_ACK   = 3'd4,
        RD_BYTE  = 3'd5,
        RD_ACK   = 3'd6
    } i2c_tgt_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_sync
// Brief    : 2-FF synchronizer, optional glitch filter (I2C_TGT_FILTER_EN),
//            and rise/fall detection for one bus line.
// Revision : 1.0
// ============================================================================
module i2c_line_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef I2C_TGT_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // The filtered level only moves after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync_q[1] == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level_o = filt_q;
`else
    logic filter_len_unused;
    assign filter_len_unused = (FILTER_LEN != 0);
    assign level_o           = sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_o;
        end
    end

    assign rise_o = level_o & ~prev_q;
    assign fall_o = ~level_o & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : I2C target with a single 7-bit address, byte write and read.
//            Define I2C_TGT_FILTER_EN to add glitch filters on SCL/SDA.
// Revision : 1.0
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
    parameter int                    FILTER_LEN  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  I2C_SCL,
    inout  wire                   I2C_SDA,
    input  logic [I2C_BYTE_W-1:0] data_in,
    output logic                  tx_req,
    output logic [I2C_BYTE_W-1:0] data_out,
    output logic                  rx_valid,
    output logic                  busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_w, stop_w;

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (I2C_SCL),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (I2C_SDA),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start_w = sda_fall & scl_lvl;
    assign stop_w  = sda_rise & scl_lvl;

    i2c_tgt_state_t        state_q, state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] data_out_q, data_out_d;
    logic                  rw_q, rw_d;
    logic                  ninth_q, ninth_d;
    logic                  drive_q, drive_d;
    logic                  tx_req_q, tx_req_d;
    logic                  rx_valid_q, rx_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            rw_q       <= 1'b0;
            ninth_q    <= 1'b0;
            drive_q    <= 1'b0;
            tx_req_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            rw_q       <= rw_d;
            ninth_q    <= ninth_d;
            drive_q    <= drive_d;
            tx_req_q   <= tx_req_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // ninth_q marks that the 9th SCL rise of an ACK slot has been seen, so the
    // next fall ends the slot instead of starting it.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        rw_d       = rw_q;
        ninth_d    = ninth_q;
        drive_d    = drive_q;
        tx_req_d   = 1'b0;
        rx_valid_d = 1'b0;

        if (start_w) begin
            state_d  = ADDR;
            bitcnt_d = '0;
            ninth_d  = 1'b0;
            drive_d  = 1'b0;
        end else if (stop_w) begin
            state_d = IDLE;
            ninth_d = 1'b0;
            drive_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rw_d    = sda_lvl;
                            state_d = (shift_q[I2C_ADDR_W-1:0] == TARGET_ADDR) ? ADDR_ACK : IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ninth_q) begin
                            drive_d = 1'b1;
                        end else begin
                            ninth_d  = 1'b0;
                            bitcnt_d = '0;
                            if (rw_q) begin
                                state_d = RD_BYTE;
                                drive_d = ~shift_q[I2C_BYTE_W-1];
                                shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            end else begin
                                state_d = WR_BYTE;
                                drive_d = 1'b0;
                            end
                        end
                    end else if (scl_rise) begin
                        ninth_d = 1'b1;
                        if (rw_q) begin
                            shift_d  = data_in;
                            tx_req_d = 1'b1;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            data_out_d = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
                            rx_valid_d = 1'b1;
                            state_d    = WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!ninth_q) begin
                            drive_d = 1'b1;
                        end else begin
                            ninth_d  = 1'b0;
                            bitcnt_d = '0;
                            drive_d  = 1'b0;
                            state_d  = WR_BYTE;
                        end
                    end else if (scl_rise) begin
                        ninth_d = 1'b1;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        drive_d = ~shift_q[I2C_BYTE_W-1];
                        shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                    end else if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = RD_ACK;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        if (!ninth_q) begin
                            drive_d = 1'b0;
                        end else begin
                            ninth_d  = 1'b0;
                            bitcnt_d = '0;
                            state_d  = RD_BYTE;
                            drive_d  = ~shift_q[I2C_BYTE_W-1];
                            shift_d  = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                        end
                    end else if (scl_rise) begin
                        if (!sda_lvl) begin
                            ninth_d  = 1'b1;
                            shift_d  = data_in;
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign I2C_SDA  = drive_q ? 1'b0 : 1'bz;
    assign data_out = data_out_q;
    assign tx_req   = tx_req_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Bus-level controller model driving random and directed transfers.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] TGT  = 7'h42;
    localparam int         HALF = 10;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       scl_drv   = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic [7:0] data_out;
    logic       tx_req, rx_valid, busy;
    wire        sda_bus;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda_bus);

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(TGT), .FILTER_LEN(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .I2C_SCL (scl_drv),
        .I2C_SDA (sda_bus),
        .data_in (data_in),
        .tx_req  (tx_req),
        .data_out(data_out),
        .rx_valid(rx_valid),
        .busy    (busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rx     = 0;
    int         n_tx     = 0;
    int         n_viol   = 0;
    logic       drv_prev = 1'b0;
    logic [7:0] m_data_out;

    // Pulse counters and a check that the target never moves SDA while SCL is high.
    always @(posedge clk) begin
        logic dd;
        #2;
        if (rx_valid) n_rx++;
        if (tx_req)   n_tx++;
        dd = !sda_bus && !m_sda_low;
        if (rst_n && scl_drv && (dd != drv_prev)) n_viol++;
        drv_prev = dd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; wait_clk(HALF);
        scl_drv   = 1'b1; wait_clk(HALF);
        m_sda_low = 1'b1; wait_clk(HALF);
        scl_drv   = 1'b0; wait_clk(HALF / 2);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_clk(HALF);
        scl_drv   = 1'b1; wait_clk(HALF);
        m_sda_low = 1'b0; wait_clk(HALF);
    endtask

    task automatic bit_xfer(input logic b, input bit glitch, output logic smp);
        m_sda_low = !b;
        wait_clk(HALF / 2);
        if (glitch) begin
            scl_drv = 1'b1; wait_clk(1);
            scl_drv = 1'b0;
        end
        wait_clk(HALF / 2);
        scl_drv = 1'b1; wait_clk(HALF / 2);
        smp     = sda_bus; wait_clk(HALF / 2);
        scl_drv = 1'b0; wait_clk(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gl, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], (i == gl), s);
        bit_xfer(1'b1, 1'b0, s);
        acked = !s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            b[i] = s;
        end
        bit_xfer(!ack, 1'b0, s);
    endtask

    // One addressed transfer of n bytes; the controller ACKs every read byte but the last.
    task automatic xfer(input logic [6:0] a, input logic rw, input int n, input bit do_stop,
                        input logic [7:0] d0, input logic [7:0] d1);
        logic       ack;
        logic       hit;
        logic [7:0] b;
        logic [7:0] q[$];
        int         rx0, tx0;
        rx0 = n_rx;
        tx0 = n_tx;
        hit = (a == TGT);
        q.push_back(d0);
        q.push_back(d1);
        for (int k = 2; k <= n; k++) q.push_back(8'($urandom));
        data_in = q[0];
        bus_start();
        send_byte({a, rw}, -1, ack);
        check("addr_ack", ack, hit);
        if (hit) begin
            for (int k = 0; k < n; k++) begin
                if (rw) begin
                    data_in = q[k + 1];
                    recv_byte(k != n - 1, b);
                    check("rd_data", b, q[k]);
                end else begin
                    send_byte(q[k], -1, ack);
                    check("wr_ack", ack, 1'b1);
                    m_data_out = q[k];
                end
            end
        end
        wait_clk(2);
        check("busy_pre_stop", busy, hit && !rw);
        if (hit && rw) check("sda_released", sda_bus, 1'b1);
        check("rx_count", n_rx - rx0, (hit && !rw) ? n : 0);
        check("tx_count", n_tx - tx0, (hit && rw) ? n : 0);
        check("data_out", data_out, m_data_out);
        if (do_stop) begin
            bus_stop();
            check("busy_after_stop", busy, 1'b0);
        end
    endtask

    initial begin
        logic ack, s;
        int   rx0;
        m_data_out = 8'h00;

        wait_clk(3);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_sda", sda_bus, 1'b1);
        rst_n = 1'b1;
        wait_clk(5);

        xfer(TGT, 1'b0, 1, 1'b1, 8'hA5, 8'h00);
        xfer(TGT, 1'b1, 1, 1'b1, 8'h3C, 8'h00);
        xfer(7'h43, 1'b0, 1, 1'b1, 8'h99, 8'h00);
        xfer(TGT, 1'b0, 1, 1'b0, 8'h11, 8'h00);
        xfer(TGT, 1'b1, 2, 1'b1, 8'h55, 8'hAA);

        // Reset during the 4th data bit of a read while the target pulls SDA low.
        bus_start();
        data_in = 8'h00;
        send_byte({TGT, 1'b1}, -1, ack);
        check("rst_mid_addr_ack", ack, 1'b1);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, 1'b0, s);
        m_sda_low = 1'b0; wait_clk(HALF);
        scl_drv   = 1'b1; wait_clk(HALF / 2);
        check("rst_mid_drive", sda_bus, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_sda", sda_bus, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_tx_req", tx_req, 1'b0);
        check("rst_mid_rx_valid", rx_valid, 1'b0);
        check("rst_mid_data_out", data_out, 8'h00);
        m_data_out = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        scl_drv = 1'b0;
        wait_clk(HALF);
        xfer(TGT, 1'b0, 1, 1'b1, 8'h5A, 8'h00);

`ifdef I2C_TGT_FILTER_EN
        rx0 = n_rx;
        bus_start();
        send_byte({TGT, 1'b0}, -1, ack);
        check("glitch_addr_ack", ack, 1'b1);
        send_byte(8'h96, 3, ack);
        check("glitch_wr_ack", ack, 1'b1);
        m_data_out = 8'h96;
        wait_clk(2);
        check("glitch_data_out", data_out, 8'h96);
        check("glitch_rx_count", n_rx - rx0, 1);
        bus_stop();
`endif

        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TGT;
            xfer(a, 1'($urandom), $urandom_range(1, 3), (t == 15) ? 1'b1 : 1'($urandom),
                 8'($urandom), 8'($urandom));
        end

        check("sda_stable_scl_high", n_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h42, the 7-bit address this target answers to.
REQ-002 SHALL have parameter FILTER_LEN, default 3, the number of stable clk samples required before a filtered line changes (used only under I2C_TGT_FILTER_EN).
REQ-003 SHALL have port clk, input, 1, system clock; one clock only.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port I2C_SCL, input, 1, bus clock from the controller.
REQ-006 SHALL have port I2C_SDA, inout, 1, open-drain data line, driven only to 0, otherwise z.
REQ-007 SHALL have port data_in, input, 8, byte returned to the controller on reads.
REQ-008 SHALL have port tx_req, output, 1, one-clk pulse when data_in is captured for transmission.
REQ-009 SHALL have port data_out, output, 8, last byte written by the controller.
REQ-010 SHALL have port rx_valid, output, 1, one-clk pulse when data_out updates.
REQ-011 SHALL have port busy, output, 1, high while addressed (state not IDLE).

Function
REQ-012 SHALL pass SCL and SDA through 2-FF synchronizers and detect rise/fall on the synchronized values.
REQ-013 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-015 START, including a repeated START, SHALL move any state to ADDR, clear the bit counter, and release SDA.
REQ-016 STOP SHALL move any state to IDLE and release SDA.
REQ-017 SHALL sample SDA on the SCL rise and change its SDA drive on the clk after the SCL fall; data is MSB first.
REQ-018 In ADDR, after 8 bits, an address match SHALL go to ADDR_ACK; a mismatch SHALL go to IDLE and stay silent until the next START.
REQ-019 ADDR_ACK SHALL drive SDA low from the 8th SCL fall to the 9th SCL fall, then go to RD_BYTE if R/W=1, otherwise to WR_BYTE.
REQ-020 When R/W=1, data_in SHALL be captured with a tx_req pulse at the 9th SCL rise of ADDR_ACK; bit 7 is driven at the following SCL fall.
REQ-021 In RD_BYTE, a shifter bit value of 0 SHALL drive SDA low and a value of 1 SHALL release it; after 8 bits the state is RD_ACK with SDA released.
REQ-022 In RD_ACK, a controller ACK (SDA=0 at SCL rise) SHALL capture data_in with a tx_req pulse and return to RD_BYTE; a NACK SHALL go to IDLE.
REQ-023 In WR_BYTE, after 8 bits, data_out SHALL load and rx_valid SHALL pulse at the 8th SCL rise; the state is then WR_ACK.
REQ-024 WR_ACK SHALL always ACK (SDA low for the 9th SCL cycle), then return to WR_BYTE.
REQ-025 SDA SHALL never change while the synchronized SCL is high, except for the release at START or STOP.
REQ-026 The bit counter SHALL be 3 bits wide and wrap 7 to 0 without overflow side effects.
REQ-027 A simultaneous START and SCL edge in the same clk SHALL give START priority.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, SDA released, data_out=8'h00, tx_req=0, rx_valid=0, busy=0, counters 0, and synchronizers to 1.
REQ-029 Reset mid-transfer SHALL release SDA immediately; after release the block waits for a new START.

Configuration
REQ-030 Macro I2C_TGT_FILTER_EN defined SHALL insert a glitch filter after each synchronizer; the filtered line follows the input only after FILTER_LEN consecutive equal samples, adding FILTER_LEN clk latency.
REQ-031 Macro I2C_TGT_FILTER_EN undefined SHALL leave no filter: the synchronizer output is used directly and FILTER_LEN is ignored.

Structure
REQ-032 Package i2c_pkg SHALL hold the i2c_tgt_state_t enum and the constants I2C_ADDR_W=7 and I2C_BYTE_W=8.
REQ-033 Sub-module i2c_line_sync (synchronizer, optional filter, rise/fall outputs) SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-034 Write 0x84 (address 0x42, W) then byte 0xA5 then STOP -> two target ACKs, data_out=0xA5 with one rx_valid pulse, busy drops after STOP.
REQ-035 Read with address byte 0x85 and data_in=0x3C, controller NACK -> tx_req pulses once, bus carries 0x3C, state IDLE after NACK, SDA released.
REQ-036 Address 0x43 W -> no ACK (SDA high at 9th SCL), busy=0, data_out unchanged.
REQ-037 Write 0x84, 0x11, repeated START, 0x85, read 2 bytes (ACK then NACK) with data_in 0x55 then 0xAA -> rx_valid once, tx_req twice, bus carries 0x55 then 0xAA.
REQ-038 rst_n asserted during the 4th data bit of a read -> SDA released within the same clk, all outputs at reset values, next transaction still ACKed.
REQ-039 Under I2C_TGT_FILTER_EN, a 1-clk SCL glitch during WR_BYTE -> bit count and data_out unaffected.
